// File: rtl/bram_pipelined_adapter.sv
// Arbitrates N ready/valid GPU channels onto one native BRAM port, one request per cycle,
// with pipelined reads returned in issue order as per-channel response pulses.
module bram_pipelined_adapter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int NUM_CHANNELS  = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_ENABLE  = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CHANNELS-1:0]                   gpu_req_valid,
  output logic [NUM_CHANNELS-1:0]                   gpu_req_ready,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   gpu_req_addr,
  input  logic [NUM_CHANNELS-1:0]                   gpu_w_valid,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   gpu_w_data,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH/8-1:0] gpu_w_strb,
  output logic [NUM_CHANNELS-1:0]                   gpu_w_ready,
  output logic [NUM_CHANNELS-1:0]                   gpu_resp_valid,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   gpu_resp_data,
  output logic                                      bram_en,
  output logic [ADDR_WIDTH-1:0]                     bram_addr,
  output logic [DATA_WIDTH/8-1:0]                   bram_we,
  output logic [DATA_WIDTH-1:0]                     bram_din,
  input  logic [DATA_WIDTH-1:0]                     bram_dout,
  output logic                                      idle
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ID_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int STAGES = READ_LATENCY + 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] wr;
  logic                    grant_valid;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_write;
  logic [ID_W-1:0]         cand;

  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic                    en_q, en_d;
  logic [STRB_W-1:0]       we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  rd_tag_t [STAGES-1:0]    pipe_q, pipe_d;
  rd_tag_t                 tail;

  logic [NUM_CHANNELS-1:0]                 resp_valid_q, resp_valid_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  // A channel's write strobe alone raises a request only when writes are supported.
  always_comb begin
    req = gpu_req_valid;
    wr  = '0;
    if (WRITE_ENABLE != 0) begin
      req = gpu_req_valid | gpu_w_valid;
      wr  = gpu_w_valid;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_valid = 1'b1;
          grant_id    = ID_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
        cand = ID_W'((int'(last_grant_q) + k) % NUM_CHANNELS);
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
    if (!reset) grant_valid = 1'b0;
    grant_write = grant_valid & wr[grant_id];
  end

  assign gpu_req_ready = grant_valid ? (NUM_CHANNELS'(1) << grant_id) : '0;
  assign gpu_w_ready   = (WRITE_ENABLE != 0) ? gpu_req_ready : '0;

  // Request side: the BRAM command register and the read-tag shift pipeline.
  always_comb begin
    en_d         = grant_valid;
    we_d         = '0;
    addr_d       = addr_q;
    din_d        = din_q;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      addr_d       = gpu_req_addr[grant_id];
      last_grant_d = grant_id;
      if (grant_write) begin
        we_d  = gpu_w_strb[grant_id];
        din_d = gpu_w_data[grant_id];
      end
    end
    pipe_d[0].valid = grant_valid & ~grant_write;
    pipe_d[0].id    = grant_id;
    for (int s = 1; s < STAGES; s++) pipe_d[s] = pipe_q[s-1];
  end

  // The last tag stage lines up with the cycle in which bram_dout carries its data.
  always_comb begin
    tail         = pipe_q[READ_LATENCY];
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tail.valid) begin
      resp_valid_d[tail.id] = 1'b1;
      resp_data_d[tail.id]  = bram_dout;
    end
    idle = ~en_q;
    for (int s = 0; s < STAGES; s++) begin
      if (pipe_q[s].valid) idle = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q         <= 1'b0;
      we_q         <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      last_grant_q <= ID_W'(NUM_CHANNELS - 1);
      pipe_q       <= '0;
      resp_valid_q <= '0;
      // NOTE: the response data array is reset because its value is visible on the
      // ports; the BRAM contents behind this adapter are never reset.
      resp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample the same pre-edge values.
      en_q         <= en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      last_grant_q <= last_grant_d;
      pipe_q       <= pipe_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bram_en        = en_q;
  assign bram_we        = we_q;
  assign bram_addr      = addr_q;
  assign bram_din       = din_q;
  assign gpu_resp_valid = resp_valid_q;
  assign gpu_resp_data  = resp_data_q;

endmodule

// File: tb/tb_bram_pipelined_adapter.sv
// Directed bench: three adapter instances (RR/lat1/RW, RR/lat3/RO, FP/lat2/RW) share stimulus,
// each backed by its own behavioural BRAM with the matching read latency.
module tb_bram_pipelined_adapter;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCH-1:0]         req_valid, w_valid;
  logic [NCH-1:0][AW-1:0] req_addr;
  logic [NCH-1:0][DW-1:0] w_data;
  logic [NCH-1:0][SW-1:0] w_strb;

  logic [NCH-1:0] ready_a, wready_a, rvalid_a;
  logic [NCH-1:0] ready_b, wready_b, rvalid_b;
  logic [NCH-1:0] ready_c, wready_c, rvalid_c;
  logic [NCH-1:0][DW-1:0] rdata_a, rdata_b, rdata_c;
  logic en_a, en_b, en_c, idle_a, idle_b, idle_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [SW-1:0] we_a, we_b, we_c;
  logic [DW-1:0] din_a, din_b, din_c, dout_a, dout_b, dout_c;

  int checks = 0;
  int errors = 0;

  bram_pipelined_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NCH),
    .READ_LATENCY(1), .WRITE_ENABLE(1), .PRIORITY_MODE(0)) u_a (
    .clk(clk), .reset(reset), .gpu_req_valid(req_valid), .gpu_req_ready(ready_a),
    .gpu_req_addr(req_addr), .gpu_w_valid(w_valid), .gpu_w_data(w_data), .gpu_w_strb(w_strb),
    .gpu_w_ready(wready_a), .gpu_resp_valid(rvalid_a), .gpu_resp_data(rdata_a),
    .bram_en(en_a), .bram_addr(addr_a), .bram_we(we_a), .bram_din(din_a),
    .bram_dout(dout_a), .idle(idle_a));

  bram_pipelined_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NCH),
    .READ_LATENCY(3), .WRITE_ENABLE(0), .PRIORITY_MODE(0)) u_b (
    .clk(clk), .reset(reset), .gpu_req_valid(req_valid), .gpu_req_ready(ready_b),
    .gpu_req_addr(req_addr), .gpu_w_valid(w_valid), .gpu_w_data(w_data), .gpu_w_strb(w_strb),
    .gpu_w_ready(wready_b), .gpu_resp_valid(rvalid_b), .gpu_resp_data(rdata_b),
    .bram_en(en_b), .bram_addr(addr_b), .bram_we(we_b), .bram_din(din_b),
    .bram_dout(dout_b), .idle(idle_b));

  bram_pipelined_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NCH),
    .READ_LATENCY(2), .WRITE_ENABLE(1), .PRIORITY_MODE(1)) u_c (
    .clk(clk), .reset(reset), .gpu_req_valid(req_valid), .gpu_req_ready(ready_c),
    .gpu_req_addr(req_addr), .gpu_w_valid(w_valid), .gpu_w_data(w_data), .gpu_w_strb(w_strb),
    .gpu_w_ready(wready_c), .gpu_resp_valid(rvalid_c), .gpu_resp_data(rdata_c),
    .bram_en(en_c), .bram_addr(addr_c), .bram_we(we_c), .bram_din(din_c),
    .bram_dout(dout_c), .idle(idle_c));

  // Behavioural BRAMs: read data appears READ_LATENCY cycles after the sampling edge.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] mem_c [256];
  logic [DW-1:0] pipe_a [1];
  logic [DW-1:0] pipe_b [3];
  logic [DW-1:0] pipe_c [2];

  always @(posedge clk) begin
    pipe_a[0] <= (en_a && we_a == '0) ? mem_a[addr_a[7:0]] : 32'hBAD0_BAD0;
    pipe_b[0] <= (en_b && we_b == '0) ? mem_b[addr_b[7:0]] : 32'hBAD0_BAD0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_c[0] <= (en_c && we_c == '0) ? mem_c[addr_c[7:0]] : 32'hBAD0_BAD0;
    pipe_c[1] <= pipe_c[0];
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 32'hA5A5_0000 | i;
        mem_b[i] <= 32'hB0B0_0000 | i;
        mem_c[i] <= 32'hC0C0_0000 | i;
      end
      mem_a[8'h10] <= 32'hDEAD_BEEF;
      mem_a[8'h20] <= 32'hAABB_CCDD;
    end else begin
      for (int j = 0; j < SW; j++) begin
        if (en_a && we_a[j]) mem_a[addr_a[7:0]][8*j +: 8] <= din_a[8*j +: 8];
        if (en_b && we_b[j]) mem_b[addr_b[7:0]][8*j +: 8] <= din_b[8*j +: 8];
        if (en_c && we_c[j]) mem_c[addr_c[7:0]][8*j +: 8] <= din_c[8*j +: 8];
      end
    end
  end

  assign dout_a = pipe_a[0];
  assign dout_b = pipe_b[2];
  assign dout_c = pipe_c[1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int            seq [3] = '{0, 1, 3};
  logic [NCH-1:0] exp_oh;
  int            ch;

  initial begin
    reset     = 1'b0;
    req_valid = '1;
    w_valid   = '0;
    req_addr  = '0;
    w_data    = '0;
    w_strb    = '0;

    // Reset state, with every channel requesting.
    repeat (2) @(posedge clk);
    mid();
    check("rst_ready_a", ready_a, 0);
    check("rst_ready_c", ready_c, 0);
    check("rst_en_a", en_a, 0);
    check("rst_idle_a", idle_a, 1);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rdata_a2", rdata_a[2], 0);
    check("rst_addr_a", addr_a, 0);
    req_valid = '0;
    reset     = 1'b1;

    // Single read on ch2, latency 1: response three cycles after the handshake.
    step(); req_valid = 8'h04; req_addr[2] = 32'h10;
    mid();  check("rd_ready", ready_a, 8'h04);
    step(); req_valid = '0;
    mid();  check("rd_en", en_a, 1); check("rd_addr", addr_a, 32'h10); check("rd_we", we_a, 0);
    step();
    mid();  check("rd_en_off", en_a, 0); check("rd_rvalid_early", rvalid_a, 0);
    step();
    mid();  check("rd_rvalid", rvalid_a, 8'h04); check("rd_rdata", rdata_a[2], 32'hDEAD_BEEF);
    step();
    mid();  check("rd_rvalid_pulse", rvalid_a, 0); check("rd_rdata_hold", rdata_a[2], 32'hDEAD_BEEF);

    // Byte-masked write on ch5 followed back-to-back by a read of the same address.
    step(); w_valid = 8'h20; req_addr[5] = 32'h20; w_data[5] = 32'h1122_3344; w_strb[5] = 4'b0101;
    mid();  check("wr_ready", ready_a, 8'h20); check("wr_wready", wready_a, 8'h20);
    step(); w_valid = '0; req_valid = 8'h20;
    mid();  check("wr_b2b_ready", ready_a, 8'h20); check("wr_en", en_a, 1);
            check("wr_we", we_a, 4'b0101); check("wr_din", din_a, 32'h1122_3344);
            check("wr_addr", addr_a, 32'h20);
    step(); req_valid = '0;
    mid();  check("rb_en", en_a, 1); check("rb_we", we_a, 0); check("rb_din_keep", din_a, 32'h1122_3344);
    step();
    mid();  check("rb_en_off", en_a, 0);
    step();
    mid();  check("rb_rvalid", rvalid_a, 8'h20); check("rb_rdata", rdata_a[5], 32'hAA22_CC44);

    // Write with strb 0: enable without byte enables, and no response.
    step(); w_valid = 8'h10; req_addr[4] = 32'h50; w_strb[4] = 4'h0; w_data[4] = 32'hFFFF_FFFF;
    mid();  check("wz_ready", ready_a, 8'h10);
    step(); w_valid = '0;
    mid();  check("wz_en", en_a, 1); check("wz_we", we_a, 0); check("wz_addr", addr_a, 32'h50);
    for (int i = 0; i < 3; i++) begin
      step(); mid(); check("wz_no_resp", rvalid_a, 0);
    end

    // Write-only request on ch1: ignored by the read-only instance.
    step(); w_valid = 8'h02; req_addr[1] = 32'h40; w_strb[1] = 4'hF; w_data[1] = 32'h1234_5678;
    mid();  check("ro_ready_b", ready_b, 0); check("ro_wready_b", wready_b, 0);
            check("ro_ready_a", ready_a, 8'h02); check("ro_wready_a", wready_a, 8'h02);
    step(); w_valid = '0;
    mid();  check("ro_en_b", en_b, 0); check("ro_en_a", en_a, 1); check("ro_we_a", we_a, 4'hF);

    repeat (6) step();
    mid();  check("idle_a", idle_a, 1); check("idle_b", idle_b, 1); check("idle_c", idle_c, 1);

    // All channels request: round-robin rotates, fixed priority always picks ch0.
    for (int i = 0; i < NCH; i++) req_addr[i] = AW'(i);
    for (int k = 0; k < 16; k++) begin
      step(); req_valid = '1;
      mid();
      exp_oh = 8'h01 << ((2 + k) % 8);
      check("rr_grant_a", ready_a, exp_oh);
      exp_oh = 8'h01 << ((6 + k) % 8);
      check("rr_grant_b", ready_b, exp_oh);
      check("fp_grant_c", ready_c, 8'h01);
      if (k >= 3) begin
        ch     = (k - 1) % 8;
        exp_oh = 8'h01 << ch;
        check("rr_resp_a", rvalid_a, exp_oh);
        check("rr_rdata_a", rdata_a[ch], 32'hA5A5_0000 | ch);
      end
    end
    step(); req_valid = '0;
    repeat (6) step();
    mid();  check("idle_b_2", idle_b, 1);

    // Pipelined reads at latency 3 from ch0, ch1, ch3: back-to-back in-order responses.
    req_addr[0] = 32'h30; req_addr[1] = 32'h31; req_addr[3] = 32'h33;
    for (int k = 0; k < 15; k++) begin
      step(); req_valid = (k < 9) ? 8'b0000_1011 : 8'h00;
      mid();
      if (k < 9) begin
        exp_oh = 8'h01 << seq[k % 3];
        check("pl_grant_b", ready_b, exp_oh);
      end
      if (k >= 5 && k <= 13) begin
        ch     = seq[(k - 5) % 3];
        exp_oh = 8'h01 << ch;
        check("pl_resp_b", rvalid_b, exp_oh);
        check("pl_rdata_b", rdata_b[ch], 32'hB0B0_0030 | ch);
      end else begin
        check("pl_no_resp_b", rvalid_b, 0);
      end
    end
    repeat (6) step();

    // Reset with three reads outstanding at latency 2.
    req_addr[0] = 32'h60;
    for (int k = 0; k < 3; k++) begin
      step(); req_valid = 8'h01;
      mid();  check("mf_grant_c", ready_c, 8'h01);
    end
    check("mf_busy_c", idle_c, 0);
    step(); req_valid = '0; reset = 1'b0;
    #1;
    check("mf_en_c", en_c, 0); check("mf_we_c", we_c, 0); check("mf_addr_c", addr_c, 0);
    check("mf_din_c", din_c, 0); check("mf_rvalid_c", rvalid_c, 0); check("mf_idle_c", idle_c, 1);
    check("mf_rdata_c0", rdata_c[0], 0);
    step(); mid(); reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(); mid();
      check("mf_quiet_c", rvalid_c, 0);
      check("mf_quiet_a", rvalid_a, 0);
      check("mf_quiet_b", rvalid_b, 0);
    end
    step(); req_valid = '1;
    mid();  check("mf_first_a", ready_a, 8'h01); check("mf_first_b", ready_b, 8'h01);
            check("mf_first_c", ready_c, 8'h01);
    step();
    mid();  check("mf_second_a", ready_a, 8'h02);
    step(); req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
